// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl - edge-triggered interrupt controller for the CPU INT/Inta handshake
//
// Collects NSRC rising-edge request lines into a pending register. Pending
// sources that are not masked are eligible. The lowest eligible index wins.
// The controller raises INT while any source is eligible and nothing is in
// service. A one-cycle Inta acknowledge latches the winner's vector and marks
// it in service. A later EOI write re-opens the controller.
//
// Ports:
//   clk     system clock, rising edge
//   clrn    asynchronous active-low reset
//   irq     [NSRC] device request lines, rising-edge sensitive
//   INT     registered interrupt request to the CPU
//   Inta    one-cycle CPU acknowledge
//   cs      register select
//   addr    [2] register index: 0 PENDING (W1C), 1 MASK, 2 VECTOR (RO), 3 EOI
//   we      write strobe
//   din     [32] write data
//   dout    [32] registered read data (one-cycle latency)
//   vec_id  [4] index of the source currently in service
// -----------------------------------------------------------------------------
module intr_ctrl #(
  parameter int          NSRC     = 8,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [NSRC-1:0] irq,
  output logic            INT,
  input  logic            Inta,
  input  logic            cs,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  output logic [3:0]      vec_id
);

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_MASK    = 2'd1,
    REG_VECTOR  = 2'd2,
    REG_EOI     = 2'd3
  } reg_e;

  logic [NSRC-1:0] irq_d;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pending_nxt;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] rise;
  logic            in_service;
  logic [31:0]     vector;
  logic [3:0]      sel;
  logic            ack;
  logic            wr;
  logic            rd;
  logic [31:0]     rdata;

  // Write data above NSRC is ignored.
  logic unused_din;
  assign unused_din = ^din[31:NSRC];

  assign rise     = irq & ~irq_d;
  assign eligible = pending & ~mask;
  assign wr       = cs & we;
  assign rd       = cs & ~we;

  // An acknowledge only counts while INT is up. It also needs an eligible
  // source: a W1C or mask write can empty the set while INT is still high,
  // and then there is nothing to hand out.
  assign ack = Inta & INT & (|eligible);

  // Priority encoder: scanning downwards leaves the lowest set index in sel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = 4'(i);
    end
  end

  // Ordering: W1C, then the acknowledge clear, then the new edges. A fresh
  // edge therefore survives a same-cycle clear from either source.
  always_comb begin
    pending_nxt = pending;
    if (wr && addr == REG_PENDING) pending_nxt = pending_nxt & ~din[NSRC-1:0];
    if (ack)                       pending_nxt[sel] = 1'b0;
    pending_nxt = pending_nxt | rise;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_PENDING: rdata = 32'(pending);
      REG_MASK:    rdata = 32'(mask);
      REG_VECTOR:  rdata = vector;
      REG_EOI:     rdata = {31'b0, in_service};
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      irq_d      <= '0;
      pending    <= '0;
      mask       <= '1;
      in_service <= 1'b0;
      vector     <= VEC_BASE;
      vec_id     <= '0;
      INT        <= 1'b0;
      dout       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values and block order doesn't matter.
      irq_d   <= irq;
      pending <= pending_nxt;

      // sel and ack above use the old mask, so a mask write in the same
      // cycle as Inta does not change which source is acknowledged.
      if (wr && addr == REG_MASK) mask <= din[NSRC-1:0];

      // Let the acknowledge win over a same-cycle EOI. This cannot happen
      // in a well-formed handshake, but it leaves the state consistent.
      if (wr && addr == REG_EOI) in_service <= 1'b0;
      if (ack) begin
        in_service <= 1'b1;
        vector     <= VEC_BASE + {26'b0, sel, 2'b00};
        vec_id     <= sel;
      end

      // Uses the registered in_service, so INT rises one cycle after EOI.
      INT <= (|eligible) & ~in_service & ~ack;

      if (rd) dout <= rdata;
    end
  end

endmodule
